// File: rtl/cv32e40s_instr_obi_responder.sv
// OBI instruction-side memory responder: single-cycle RAM reads, in-order responses, at most DEPTH outstanding.
// Response arrives 1 cycle after grant when unstalled; resp_stall_i buffers beats and grant drops once DEPTH are outstanding.
module cv32e40s_instr_obi_responder #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MEM_AW   = 10,
    parameter logic [31:0] ERR_BASE = 32'h0001_0000,
    parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              obi_req_i,
    input  logic [31:0]       obi_addr_i,
    output logic              obi_gnt_o,
    output logic              obi_rvalid_o,
    output logic [31:0]       obi_rdata_o,
    output logic              obi_err_o,
    input  logic              resp_stall_i,
    output logic              mem_req_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
    output logic [CNT_W-1:0]  outstnd_cnt_o,
    output logic              protocol_err_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } beat_t;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_err_q, rd_err_d;
    logic             req_q, req_d;
    logic             gnt_q, gnt_d;
    logic [31:0]      addr_q, addr_d;
    logic             protocol_err_q, protocol_err_d;
    beat_t            fifo_q [DEPTH];

    logic  gnt, acc, in_err;
    logic  fifo_empty, fifo_full;
    logic  bypass, pop, push, rvalid;
    beat_t beat, out_beat;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        gnt        = cnt_q < CNT_W'(DEPTH);
        acc        = obi_req_i & gnt;
        in_err     = obi_addr_i >= ERR_BASE;
        mem_req_o  = acc & ~in_err;
        mem_addr_o = mem_req_o ? obi_addr_i[MEM_AW+1:2] : '0;

        // Error-region beats never look at RAM data, which may be stale.
        beat.rdata = rd_err_q ? 32'h0 : mem_rdata_i;
        beat.err   = rd_err_q;

        fifo_empty = (fill_q == '0);
        fifo_full  = (fill_q == CNT_W'(DEPTH));
        bypass     = fifo_empty & ~resp_stall_i & rd_pend_q;
        pop        = ~fifo_empty & ~resp_stall_i;
        push       = rd_pend_q & ~bypass;
        rvalid     = bypass | pop;

        out_beat = '0;
        if (bypass) begin
            out_beat = beat;
        end else if (pop) begin
            out_beat = fifo_q[rd_ptr_q];
        end

        fill_d = fill_q;
        if (push && !pop) begin
            fill_d = fill_q + 1'b1;
        end else if (pop && !push) begin
            fill_d = fill_q - 1'b1;
        end
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        cnt_d = cnt_q;
        if (acc && !rvalid) begin
            cnt_d = cnt_q + 1'b1;
        end else if (rvalid && !acc) begin
            cnt_d = cnt_q - 1'b1;
        end

        rd_pend_d = acc;
        rd_err_d  = acc & in_err;

        // A stalled request must be held with a stable address until granted.
        req_d          = obi_req_i;
        gnt_d          = gnt;
        addr_d         = obi_addr_i;
        protocol_err_d = protocol_err_q |
                         (req_q & ~gnt_q & (~obi_req_i | (obi_addr_i != addr_q)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q          <= '0;
            fill_q         <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            rd_pend_q      <= 1'b0;
            rd_err_q       <= 1'b0;
            req_q          <= 1'b0;
            gnt_q          <= 1'b0;
            addr_q         <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            fill_q         <= fill_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            rd_pend_q      <= rd_pend_d;
            rd_err_q       <= rd_err_d;
            req_q          <= req_d;
            gnt_q          <= gnt_d;
            addr_q         <= addr_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= beat;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

    assign obi_gnt_o      = gnt;
    assign obi_rvalid_o   = rvalid;
    assign obi_rdata_o    = out_beat.rdata;
    assign obi_err_o      = out_beat.err;
    assign outstnd_cnt_o  = cnt_q;
    assign protocol_err_o = protocol_err_q;

endmodule

// File: doc/cv32e40s_instr_obi_responder.md
Name: cv32e40s_instr_obi_responder

Overview:
- Synthesizable OBI instruction-side responder: the memory end of the fetch path driven by the prefetcher / instruction OBI interface.
- Accepts address-phase requests (req/gnt/addr) and issues single-cycle synchronous reads to a word-addressed instruction RAM.
- Returns in-order response-phase beats (rvalid/rdata/err) with a bounded outstanding count, an error region and injectable response stalls.
- Used in the core-level integration bench and FPGA bring-up as the instruction memory slave.

Parameters:
- DEPTH, 2, maximum outstanding (granted, not yet responded) transactions; legal range 1..4.
- MEM_AW, 10, instruction RAM word-address width.
- ERR_BASE, 32'h0001_0000, byte addresses >= ERR_BASE respond with err=1.
- CNT_W, $clog2(DEPTH+1), outstanding-counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- obi_req_i  in  1  address-phase request
- obi_addr_i  in  32  request byte address (word aligned; bits [1:0] ignored)
- obi_gnt_o  out  1  address-phase grant
- obi_rvalid_o  out  1  response valid (no rready; initiator always accepts)
- obi_rdata_o  out  32  response data
- obi_err_o  out  1  response error
- resp_stall_i  in  1  suppress rvalid this cycle (bench/latency injection)
- mem_req_o  out  1  RAM read enable
- mem_addr_o  out  MEM_AW  RAM word address
- mem_rdata_i  in  32  RAM read data, valid the cycle after mem_req_o
- outstnd_cnt_o  out  CNT_W  current outstanding count
- protocol_err_o  out  1  sticky initiator protocol violation flag

Behaviour:
- Reset: asynchronous, active-high. Clears cnt, FIFO pointers, rd_pend and protocol_err; any in-flight read is discarded. mem_rdata_i in the cycle after reset release is ignored.
- Reset output values: obi_gnt_o=1 (cnt=0); all other outputs 0.
- Grant: obi_gnt_o = (cnt_q < DEPTH). It is independent of obi_req_i and has no same-cycle bypass from a retiring response.
- Accept event: acc = obi_req_i & obi_gnt_o.
- Read issue: on acc with addr < ERR_BASE, mem_req_o=1 and mem_addr_o=addr[MEM_AW+1:2]. Otherwise mem_req_o=0 and mem_addr_o=0.
- Beat capture: registered rd_pend (1 bit) and rd_err flag record an accept.
  - Next cycle, the beat is {mem_rdata_i, 0}, or {32'h0, 1} if it was an error-region access.
- Response FIFO: DEPTH entries of {rdata, err}, in order.
  - Bypass: if the FIFO is empty, resp_stall_i=0 and rd_pend_q=1, the beat goes directly to the outputs (rvalid 1 cycle after grant, the minimum latency).
  - Otherwise the beat is pushed to the FIFO.
  - The head is presented when the FIFO is non-empty and resp_stall_i=0; a presented head pops the same cycle.
- Output gating: when obi_rvalid_o=0, obi_rdata_o=0 and obi_err_o=0.
- FIFO bounds: it cannot overflow (cnt <= DEPTH). A push into a full FIFO is an internal assertion failure. Pointers wrap modulo DEPTH.
- Outstanding counter: cnt_d = cnt_q + acc - obi_rvalid_o. Simultaneous accept and response leaves it unchanged. outstnd_cnt_o = cnt_q.
- Ordering: responses are strictly in accept order, including error beats interleaved with good ones.
- Protocol check: registered req_q, gnt_q, addr_q. If req_q & !gnt_q and this cycle has !obi_req_i or obi_addr_i != addr_q, protocol_err_o is set the next cycle and stays set until rst.
- Stall: resp_stall_i holds all buffered beats. Grants continue until cnt reaches DEPTH, then obi_gnt_o=0 until a response retires.

Test Plan:
- Back-to-back fetches: req high with addr 0x0, 0x4, 0x8, RAM word n = 0xA000_000n, no stall. Expect gnt every cycle; rvalid 1 cycle after each grant with rdata 0xA0000000, 0xA0000001, 0xA0000002; err=0; outstnd_cnt_o peaks at 1.
- Backpressure: DEPTH=2, resp_stall_i=1 for 5 cycles, continuous req. Expect exactly 2 grants, then gnt_o=0 and outstnd_cnt_o=2. After stall release, 2 in-order beats; gnt reasserts the cycle after cnt drops to 1.
- Error region: accept 0x0001_0000 between 0x10 and 0x14. Expect no mem_req_o for the middle access; beats return in order as {data,0}, {0x0,1}, {data,0}.
- Protocol violation: req=1 while gnt=0 (cnt full), next cycle addr changes 0x20 -> 0x24. Expect protocol_err_o=1 the following cycle, still 1 after 10 cycles; no effect on data beats.
- Reset mid-operation: assert rst with 2 outstanding and 1 beat buffered. Expect immediate rvalid=0, cnt=0, gnt_o=1. After release, no stale beat appears and a fresh fetch of 0x0 returns the correct data.
